// File: rtl/mem_port_arbiter.sv
// Arbitrates the single CPU memory port between instruction fetch (I) and load/store (D).
// Handshake: a requester holds req (and its address/data) until it sees its one-cycle done pulse.
module mem_port_arbiter #(
  parameter int WIDTH           = 16,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_done,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_done,
  output logic             err,
  output logic             readM,
  output logic             writeM,
  output logic [WIDTH-1:0] address,
  inout  tri   [WIDTH-1:0] data,
  input  logic             mem_ready,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam bit         TIMEOUT_EN = (TIMEOUT != 0);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;   // 1 = D requester owns the access
  logic [3:0]       streak_q, streak_d;
  logic [7:0]       timer_q, timer_d;
  logic             readm_q, readm_d;
  logic             writem_q, writem_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;
  logic             err_q, err_d;
  logic             grant_i, grant_d;
  logic             finish;

  assign data      = writem_q ? wdata_q : {WIDTH{1'bz}};
  assign readM     = readm_q;
  assign writeM    = writem_q;
  assign address   = addr_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    timer_d   = timer_q;
    readm_d   = readm_q;
    writem_d  = writem_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins ties until it has taken STREAK_MAX grants in a row past a waiting fetch.
        grant_i = i_req && (!d_req || (streak_q >= STREAK_MAX));
        grant_d = d_req && !grant_i;
        if (!i_req) streak_d = 4'd0;
        if (grant_i) begin
          owner_d  = 1'b0;
          addr_d   = i_addr;
          readm_d  = 1'b1;
          writem_d = 1'b0;
          streak_d = 4'd0;
          state_d  = ACCESS;
        end else if (grant_d) begin
          owner_d  = 1'b1;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          readm_d  = !d_we;
          writem_d = d_we;
          if (i_req && (streak_q < STREAK_MAX)) streak_d = streak_q + 4'd1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        timer_d = timer_q + 8'd1;
        if (mem_ready) begin
          finish = 1'b1;
          if (readm_q) begin
            if (owner_q) d_rdata_d = data;
            else         i_rdata_d = data;
          end
        end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end
        if (finish) begin
          readm_d  = 1'b0;
          writem_d = 1'b0;
          i_done_d = !owner_q;
          d_done_d = owner_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        timer_d = 8'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      streak_q  <= 4'd0;
      timer_q   <= 8'd0;
      readm_q   <= 1'b0;
      writem_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      timer_q   <= timer_d;
      readm_q   <= readm_d;
      writem_q  <= writem_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-timeline model plays both requesters and the memory,
// and every cycle the DUT outputs are compared against the timeline it predicts.
module tb_mem_port_arbiter;
  localparam int W    = 16;
  localparam int MAXS = 4;
  localparam int TO   = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [W-1:0]  i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [W-1:0]  i_rdata, d_rdata, address;
  logic          i_done, d_done, err, readM, writeM;
  logic [1:0]    dbg_state;
  wire  [W-1:0]  data_bus;
  logic          mem_drive = 1'b0;
  logic [W-1:0]  mem_val = '0;
  assign data_bus = mem_drive ? mem_val : {W{1'bz}};

  mem_port_arbiter #(.WIDTH(W), .MAX_DATA_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .err(err), .readM(readM), .writeM(writeM), .address(address), .data(data_bus),
    .mem_ready(mem_ready), .dbg_state(dbg_state)
  );

  // Second instance with the timeout disabled.
  logic          reset0 = 1'b1, i_req0 = 1'b0, d_req0 = 1'b0, d_we0 = 1'b0, mem_ready0 = 1'b0;
  logic [W-1:0]  i_addr0 = '0, d_addr0 = '0, d_wdata0 = '0;
  logic [W-1:0]  i_rdata0, d_rdata0, address0;
  logic          i_done0, d_done0, err0, readM0, writeM0;
  logic [1:0]    dbg_state0;
  wire  [W-1:0]  data0;

  mem_port_arbiter #(.WIDTH(W), .MAX_DATA_STREAK(MAXS), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset0), .i_req(i_req0), .i_addr(i_addr0), .i_rdata(i_rdata0), .i_done(i_done0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0), .d_rdata(d_rdata0), .d_done(d_done0),
    .err(err0), .readM(readM0), .writeM(writeM0), .address(address0), .data(data0),
    .mem_ready(mem_ready0), .dbg_state(dbg_state0)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] done_seq[$];

  // model: current transaction timeline and persistent outputs
  logic         cur_v = 1'b0, cur_d = 1'b0, cur_we = 1'b0, cur_err = 1'b0;
  int           g = 0, k = 0, lat = 0, idle_at = 0, streak = 0;
  logic [W-1:0] cur_addr = '0, cur_wdata = '0, cur_mval = '0;
  logic [W-1:0] m_addr = '0, m_irdata = '0, m_drdata = '0;
  logic         rst_next = 1'b1, want_reset = 1'b0;

  // stimulus knobs
  int           i_raise_pct = 0, d_raise_pct = 0, i_renew_pct = 0, d_renew_pct = 0;
  int           fixed_lat = 0, noise_pct = 25;
  logic         use_fixed_mval = 1'b0;
  logic [W-1:0] fixed_mval = '0;
  logic         dir_i = 1'b0, dir_d = 1'b0, dir_d_we = 1'b0;
  logic [W-1:0] dir_i_addr = '0, dir_d_addr = '0, dir_d_wdata = '0;

  // observations of the DUT for the hand-computed checks
  int           obs_readM, obs_writeM, obs_idone, obs_ddone, obs_idone_cyc, obs_ddone_cyc;
  logic [W-1:0] obs_irdata, obs_wbus, obs_addr;
  logic         obs_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
  endtask

  task automatic clear_obs();
    obs_readM = 0; obs_writeM = 0; obs_idone = 0; obs_ddone = 0;
    obs_idone_cyc = 0; obs_ddone_cyc = 0;
    obs_irdata = '0; obs_wbus = '0; obs_addr = '0; obs_err = 1'b0;
    done_seq.delete();
  endtask

  // ---------------- driver: one cycle of compare + requesters + memory ----------------
  task automatic step();
    logic acc, resp, e_wr;
    int   r;
    @(negedge clk);
    cyc++;
    if (rst_next) begin
      cur_v = 1'b0; m_addr = '0; m_irdata = '0; m_drdata = '0;
      streak = 0; idle_at = cyc; rst_next = 1'b0; reset = 1'b0;
    end
    acc  = cur_v && (cyc >= g + 1) && (cyc <= g + k);
    resp = cur_v && (cyc == g + k + 1);
    if (cur_v && (cyc == g + 1)) m_addr = cur_addr;
    if (resp && !cur_err && !(cur_d && cur_we)) begin
      if (cur_d) m_drdata = cur_mval;
      else       m_irdata = cur_mval;
    end
    e_wr = acc && cur_d && cur_we;
    check("readM",   readM,   acc && !e_wr);
    check("writeM",  writeM,  e_wr);
    check("i_done",  i_done,  resp && !cur_d);
    check("d_done",  d_done,  resp && cur_d);
    check("err",     err,     resp && cur_err);
    check("address", address, m_addr);
    check("i_rdata", i_rdata, m_irdata);
    check("d_rdata", d_rdata, m_drdata);
    check("state",   dbg_state, acc ? 2'd1 : (resp ? 2'd2 : 2'd0));
    if (e_wr) check("write_bus", data_bus, cur_wdata);

    if (readM)  begin obs_readM++; obs_addr = address; end
    if (writeM) begin obs_writeM++; obs_wbus = data_bus; obs_addr = address; end
    if (i_done) begin obs_idone++; obs_idone_cyc = cyc; obs_irdata = i_rdata; obs_err = err; done_seq.push_back(16'd0); end
    if (d_done) begin obs_ddone++; obs_ddone_cyc = cyc; obs_err = err; done_seq.push_back(16'd1); end

    if (want_reset) begin
      want_reset = 1'b0; reset = 1'b1; rst_next = 1'b1;
      i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_drive = 1'b0;
      return;
    end

    // requesters renew or drop on their done, otherwise may raise a new request
    if (resp && !cur_d) begin
      if ($urandom_range(0, 99) < i_renew_pct) i_addr = 16'($urandom);
      else i_req = 1'b0;
    end
    if (resp && cur_d) begin
      if ($urandom_range(0, 99) < d_renew_pct) begin
        d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom_range(0, 1));
      end else d_req = 1'b0;
    end
    if (!i_req) begin
      if (dir_i) begin i_req = 1'b1; i_addr = dir_i_addr; dir_i = 1'b0; end
      else if ($urandom_range(0, 99) < i_raise_pct) begin i_req = 1'b1; i_addr = 16'($urandom); end
    end
    if (!d_req) begin
      if (dir_d) begin d_req = 1'b1; d_addr = dir_d_addr; d_wdata = dir_d_wdata; d_we = dir_d_we; dir_d = 1'b0; end
      else if ($urandom_range(0, 99) < d_raise_pct) begin
        d_req = 1'b1; d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom_range(0, 1));
      end
    end

    // arbitration on the requests the DUT will sample at the coming edge
    if (cyc == idle_at) begin
      if (!i_req) streak = 0;
      if (i_req && (!d_req || streak >= MAXS)) begin
        cur_v = 1'b1; cur_d = 1'b0; cur_we = 1'b0; cur_addr = i_addr; streak = 0;
      end else if (d_req) begin
        cur_v = 1'b1; cur_d = 1'b1; cur_we = d_we; cur_addr = d_addr; cur_wdata = d_wdata;
        if (i_req && streak < MAXS) streak++;
      end
      if (cur_v && (cyc == idle_at) && (i_req || d_req)) begin
        g = cyc;
        if (fixed_lat > 0) lat = fixed_lat;
        else begin
          r = $urandom_range(0, 19);
          lat = (r < 15) ? $urandom_range(1, 4) : ((r < 17) ? TO : 99);
        end
        cur_err  = (lat > TO);
        k        = cur_err ? TO : lat;
        cur_mval = use_fixed_mval ? fixed_mval : 16'($urandom);
        idle_at  = g + k + 2;
      end else idle_at = cyc + 1;
    end

    // memory: answers in the chosen ACCESS cycle, noise on mem_ready elsewhere
    if (cur_v && (cyc >= g + 1) && (cyc <= g + k)) begin
      mem_ready = (cyc == g + lat);
      mem_drive = mem_ready && !(cur_d && cur_we);
      mem_val   = cur_mval;
    end else begin
      mem_ready = ($urandom_range(0, 99) < noise_pct);
      mem_drive = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_raise_pct = 0; d_raise_pct = 0; i_renew_pct = 0; d_renew_pct = 0;
    while ((i_req || d_req || (cur_v && cyc < g + k + 2)) && n < 300) begin
      step();
      n++;
    end
    check("drain_bounded", (n < 300), 1'b1);
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    step();
    step();

    // I-only read, memory answers in the 2nd strobe cycle
    clear_obs(); fixed_lat = 2; use_fixed_mval = 1'b1; fixed_mval = 16'hA5A5;
    dir_i = 1'b1; dir_i_addr = 16'h0010;
    run(8);
    check("iread_readM_cycles", obs_readM, 2);
    check("iread_addr", obs_addr, 16'h0010);
    check("iread_done_count", obs_idone, 1);
    check("iread_rdata", obs_irdata, 16'hA5A5);
    check("iread_err", obs_err, 1'b0);

    // timeout: memory never answers, rdata must keep 0xA5A5
    clear_obs(); fixed_lat = 99; dir_i = 1'b1; dir_i_addr = 16'h0020;
    run(20);
    check("tmo_readM_cycles", obs_readM, 15);
    check("tmo_done_count", obs_idone, 1);
    check("tmo_err", obs_err, 1'b1);
    check("tmo_rdata_kept", obs_irdata, 16'hA5A5);

    // D write with one-cycle memory
    clear_obs(); fixed_lat = 1; dir_d = 1'b1; dir_d_we = 1'b1;
    dir_d_addr = 16'h0200; dir_d_wdata = 16'h1234;
    run(6);
    check("dwr_writeM_cycles", obs_writeM, 1);
    check("dwr_bus", obs_wbus, 16'h1234);
    check("dwr_addr", obs_addr, 16'h0200);
    check("dwr_done_count", obs_ddone, 1);
    check("dwr_err", obs_err, 1'b0);

    // simultaneous requests: D read first, I done 3 cycles later
    clear_obs(); use_fixed_mval = 1'b0; fixed_lat = 1;
    dir_i = 1'b1; dir_i_addr = 16'h0040; dir_d = 1'b1; dir_d_we = 1'b0; dir_d_addr = 16'h0300;
    run(10);
    check("sim_d_done_count", obs_ddone, 1);
    check("sim_i_done_count", obs_idone, 1);
    check("sim_i_after_d", obs_idone_cyc - obs_ddone_cyc, 3);
    drain();

    // starvation bound: D renews forever, I waits
    clear_obs(); fixed_lat = 1; d_renew_pct = 100;
    dir_d = 1'b1; dir_d_we = 1'b0; dir_d_addr = 16'h0500; dir_i = 1'b1; dir_i_addr = 16'h0600;
    for (int i = 0; i < 60 && done_seq.size() < 6; i++) step();
    exp_q = {16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd1};
    for (int i = 0; i < 6; i++)
      check("starve_order", (i < done_seq.size()) ? done_seq[i] : 16'hFFFF, exp_q[i]);
    drain();

    // randomized traffic
    fixed_lat = 0; noise_pct = 25;
    i_raise_pct = 30; d_raise_pct = 30; i_renew_pct = 40; d_renew_pct = 40;
    run(1500);
    drain();

    // reset in the middle of a write
    clear_obs(); fixed_lat = 99; dir_d = 1'b1; dir_d_we = 1'b1;
    dir_d_addr = 16'h0400; dir_d_wdata = 16'hBEEF;
    run(4);
    check("pre_rst_writeM", writeM, 1'b1);
    want_reset = 1'b1;
    step();
    step();
    check("rst_writeM", writeM, 1'b0);
    clear_obs();
    run(5);
    check("rst_no_done", obs_ddone + obs_idone, 0);
    clear_obs(); fixed_lat = 2; dir_d = 1'b1; dir_d_we = 1'b1;
    dir_d_addr = 16'h0404; dir_d_wdata = 16'h5A5A;
    run(8);
    check("post_rst_writeM_cycles", obs_writeM, 2);
    check("post_rst_bus", obs_wbus, 16'h5A5A);
    check("post_rst_done", obs_ddone, 1);
    check("post_rst_err", obs_err, 1'b0);
    drain();

    // timeout disabled: readM stays up indefinitely
    begin
      int rd_cnt, dn_cnt;
      rd_cnt = 0; dn_cnt = 0;
      @(negedge clk);
      reset0 = 1'b0; i_addr0 = 16'h0030; i_req0 = 1'b1;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (readM0) rd_cnt++;
        if (i_done0 || d_done0 || err0) dn_cnt++;
      end
      check("notmo_readM_cycles", rd_cnt, 60);
      check("notmo_no_done", dn_cnt, 0);
      check("notmo_addr", address0, 16'h0030);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port (readM, writeM, address, bidirectional data) between two requesters: the instruction-fetch requester (I) and the load/store data requester (D).
- Sits between the datapath/control unit and external memory, replacing direct datapath drive of the bus.
- Sequences one access at a time, with data priority, a bounded anti-starvation rule for fetch, and a memory-response timeout.

Parameters:
- WIDTH, 16, word width of address and data (equals the codebase word size).
- MAX_DATA_STREAK, 4, maximum consecutive D grants while I is waiting; range 1..15.
- TIMEOUT, 15, cycles to wait for mem_ready before aborting; 0 disables the timeout; range 0..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; level, held until i_done.
- i_addr  in  WIDTH  fetch address; stable while i_req=1.
- i_rdata  out  WIDTH  fetched word; valid while i_done=1.
- i_done  out  1  one-cycle completion pulse for a fetch.
- d_req  in  1  data request; level, held until d_done.
- d_we  in  1  1 = write, 0 = read; stable while d_req=1.
- d_addr  in  WIDTH  data address; stable while d_req=1.
- d_wdata  in  WIDTH  write data; stable while d_req=1.
- d_rdata  out  WIDTH  load result; valid while d_done=1.
- d_done  out  1  one-cycle completion pulse for a data access.
- err  out  1  high with a done pulse when that access timed out.
- readM  out  1  memory read strobe.
- writeM  out  1  memory write strobe.
- address  out  WIDTH  memory address.
- data  inout  WIDTH  memory data bus; driven only while writeM=1, otherwise high-Z.
- mem_ready  in  1  memory completion; sampled only in the ACCESS state.

Behaviour:
- All outputs are registered. Reset values: readM=0, writeM=0, address=0, data high-Z, i_done=0, d_done=0, err=0, i_rdata=0, d_rdata=0, state=IDLE, streak=0, timer=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration on the sampled requests:
  - Only i_req=1: grant I.
  - Only d_req=1: grant D.
  - Both high: grant D unless streak ≥ MAX_DATA_STREAK, in which case grant I.
  - On grant, go to ACCESS next edge with address set to the granted address.
  - Strobes on grant: I sets readM=1. D sets writeM=d_we and readM=~d_we; a D write drives data=d_wdata.
  - The granted owner is latched in a register.
- Streak counter:
  - Increments on a D grant made while i_req=1.
  - Clears on any I grant and whenever i_req=0 in IDLE.
  - Saturates at MAX_DATA_STREAK.
- ACCESS:
  - Strobes, address and write data are held constant. Timer increments every cycle.
  - mem_ready=1: capture data into the owner's rdata (reads only), drop the strobes, release data to Z, go to RESP with the owner's done=1 and err=0.
  - Timer reaches TIMEOUT (TIMEOUT≠0) with no mem_ready: same transition, but rdata is left unchanged and err=1.
  - mem_ready and timeout in the same cycle: mem_ready wins, err=0.
- RESP: done and err are high for exactly this one cycle. Timer clears. Next edge goes to IDLE.
- Latency: req sampled in IDLE in cycle N → strobe visible in cycle N+1 → mem_ready in cycle M → done in cycle M+1 → IDLE in M+2. Minimum 3 cycles per access.
- Requesters drop or renew req on the edge at which they see done. A req still high in IDLE is a new access.
- mem_ready outside ACCESS is ignored.
- Reset mid-access: next edge forces IDLE, strobes 0, data Z. No done pulse is produced, and the in-flight access is lost.
- Only one of i_done and d_done is ever high in a cycle. readM and writeM are never high together.

Test Plan:
- I-only read: i_req=1, i_addr=0x0010; memory returns 0xA5A5 with mem_ready 2 cycles after readM rises → readM=1 and address=0x0010 for 2 cycles; i_done=1 for 1 cycle with i_rdata=0xA5A5 and err=0; the bus stays Z throughout.
- D write: d_req=1, d_we=1, d_addr=0x0200, d_wdata=0x1234; mem_ready 1 cycle after the strobe → writeM=1 and data=0x1234 on the bus for 1 cycle, then Z; d_done pulses once with err=0.
- Simultaneous requests: i_req and d_req rise in the same cycle, d_we=0 → the D read is served first (d_done first), then I (i_done pulses 3 cycles later with zero-wait memory).
- Starvation bound: d_req held high with a new access each time, i_req held high, MAX_DATA_STREAK=4 → exactly 4 d_done pulses precede the first i_done; then D resumes and streak is 0.
- Timeout: TIMEOUT=15, I read with mem_ready never asserted → readM high for 15 cycles, then i_done=1 and err=1 with i_rdata unchanged. Repeat with TIMEOUT=0 → readM stays high indefinitely.
- Reset mid-write: reset asserted for 1 cycle while writeM=1 → next cycle writeM=0, data Z, no d_done; a subsequent D request is serviced normally from IDLE.
